// File: rtl/al_pkg.sv
// rtl/al_pkg.sv - shared types and default sizes for the active-list commit reader.
package al_pkg;

  localparam int AL_DEPTH      = 16;
  localparam int AL_INDEX      = 4;
  localparam int AL_WIDTH      = 8;
  localparam int AL_COMMIT_W   = 4;
  localparam int AL_DISPATCH_W = 4;
  localparam int COMMIT_W_LOG  = $clog2(AL_COMMIT_W + 1);

  typedef logic [AL_INDEX-1:0] alIdx_t;
  typedef logic [AL_INDEX:0]   alCnt_t;

  typedef enum logic {
    WAIT_RAM = 1'b0,
    RUN      = 1'b1
  } al_state_e;

endpackage

// File: rtl/al_ptr_add.sv
// rtl/al_ptr_add.sv - modular pointer add, (ptr + inc) mod DEPTH for non-power-of-2 depths.
module al_ptr_add #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4
) (
  input  logic [INDEX-1:0] ptr_i,
  input  logic [INDEX:0]   inc_i,
  output logic [INDEX-1:0] sum_o
);

  localparam int RW = INDEX + 2;

  logic [RW-1:0] raw;

  // Operands stay below 2*DEPTH, so a single conditional subtract is enough.
  always_comb begin
    raw   = RW'(ptr_i) + RW'(inc_i);
    sum_o = (raw >= RW'(DEPTH)) ? INDEX'(raw - RW'(DEPTH)) : INDEX'(raw);
  end

endmodule

// File: rtl/al_commit_reader.sv
// rtl/al_commit_reader.sv - reads the active-list RAM at head and stages a commit bundle for retire.
module al_commit_reader
  import al_pkg::*;
#(
  parameter int DEPTH      = AL_DEPTH,
  parameter int INDEX      = AL_INDEX,
  parameter int WIDTH      = AL_WIDTH,
  parameter int COMMIT_W   = AL_COMMIT_W,
  parameter int DISPATCH_W = AL_DISPATCH_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ramReady_i,
  input  logic [$clog2(DISPATCH_W+1)-1:0]     dispatchCnt_i,
  input  logic [COMMIT_W-1:0]                 laneActive_i,
  input  logic                                flush_i,
  output logic [COMMIT_W*INDEX-1:0]           rdAddr_o,
  input  logic [COMMIT_W*WIDTH-1:0]           rdData_i,
  output logic [COMMIT_W-1:0]                 commitValid_o,
  output logic [COMMIT_W*WIDTH-1:0]           commitData_o,
  input  logic                                commitReady_i,
  output logic [INDEX-1:0]                    head_o,
  output logic [INDEX:0]                      count_o,
  output logic                                full_o,
  output logic                                overflow_o
);

  localparam int CNT_W = INDEX + 1;
  localparam int SUM_W = INDEX + 3;

  al_state_e                state_q, state_d;
  logic [INDEX-1:0]         head_q, head_d, head_nxt;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [COMMIT_W-1:0]      valid_q, valid_d;
  logic [COMMIT_W*WIDTH-1:0] data_q, data_d;
  logic                     overflow_q, overflow_d;

  logic [CNT_W-1:0]         active_n, bundle_n, n_load, head_inc;
  logic                     accept, load;
  logic [SUM_W-1:0]         occ_sum;

  genvar g;
  generate
    for (g = 0; g < COMMIT_W; g++) begin : g_rd_lane
      al_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_lane_add (
        .ptr_i (head_q),
        .inc_i (CNT_W'(g)),
        .sum_o (rdAddr_o[g*INDEX +: INDEX])
      );
    end
  endgenerate

  // One adder serves both the normal advance and the flush jump to the tail.
  al_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_head_add (
    .ptr_i (head_q),
    .inc_i (head_inc),
    .sum_o (head_nxt)
  );

  always_comb begin
    active_n = '0;
    bundle_n = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      active_n = active_n + CNT_W'(laneActive_i[i]);
      bundle_n = bundle_n + CNT_W'(valid_q[i]);
    end
  end

  always_comb begin
    accept = valid_q[0] & commitReady_i;
    load   = (state_q == RUN) && !flush_i && (count_q != '0) && ((valid_q == '0) || accept);
    n_load = '0;
    if (load) begin
      n_load = count_q;
      if (n_load > CNT_W'(COMMIT_W)) n_load = CNT_W'(COMMIT_W);
      if (n_load > active_n)         n_load = active_n;
    end
    head_inc = flush_i ? count_q : n_load;
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_nxt;
    count_d    = count_q;
    valid_d    = valid_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    occ_sum    = SUM_W'(count_q) + SUM_W'(bundle_n) + SUM_W'(dispatchCnt_i) - SUM_W'(n_load);

    if (state_q == WAIT_RAM && ramReady_i) state_d = RUN;

    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      if (accept) valid_d = '0;
      if (load) begin
        for (int i = 0; i < COMMIT_W; i++) begin
          valid_d[i] = (CNT_W'(i) < n_load);
          if (CNT_W'(i) < n_load) data_d[i*WIDTH +: WIDTH] = rdData_i[i*WIDTH +: WIDTH];
        end
      end
      // Saturate so that live entries plus staged lanes never exceed the list.
      if (occ_sum > SUM_W'(DEPTH)) begin
        overflow_d = 1'b1;
        count_d    = CNT_W'(DEPTH) - bundle_n;
      end else begin
        count_d = CNT_W'(SUM_W'(count_q) + SUM_W'(dispatchCnt_i) - SUM_W'(n_load));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_RAM;
      head_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign commitValid_o = valid_q;
  assign commitData_o  = data_q;
  assign head_o        = head_q;
  assign count_o       = count_q;
  assign full_o        = ((count_q + bundle_n) == CNT_W'(DEPTH));
  assign overflow_o    = overflow_q;

endmodule
